// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================
// Package : adder_pkg
// Brief   : Shared sizing helpers for the sliced pipelined adder.
// Rev     : 1.0
// ============================================================
package adder_pkg;

    function automatic int slice_width(input int n, input int stages);
        return n / stages;
    endfunction

    function automatic bit params_ok(input int n, input int stages);
        return (stages >= 1) && (stages <= n) && ((n % stages) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/adder.sv
`default_nettype none
// ============================================================
// Module : adder
// Brief  : Combinational W-bit adder with carry in and carry out.
// Rev    : 1.0
// ============================================================
module adder #(
    parameter int W = 16
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_cin,
    output logic [W-1:0] o_s,
    output logic         o_cout
);

    assign {o_cout, o_s} = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, i_cin};

endmodule
`default_nettype wire

// File: rtl/pipelined_adder.sv
`default_nettype none
// ============================================================
// Module : pipelined_adder
// Brief  : N-bit add/sub split into STAGES slices, carry registered
//          between slices, valid/ready on both sides.
// Rev    : 1.0
// ============================================================
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int N      = 64,
    parameter int STAGES = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_carry_in,
    input  logic         i_sub,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [N-1:0] o_s,
    output logic         o_carry_out,
    output logic         o_overflow
);

    localparam int c_slice_w = slice_width(N, STAGES);

    if (!params_ok(N, STAGES)) begin : g_param_check
        $error("pipelined_adder: N must be a multiple of STAGES and 1 <= STAGES <= N");
    end

    logic         w_adv;
    logic [N-1:0] w_b_eff;
    logic         w_cin_eff;

    assign w_adv     = !o_valid || i_ready;
    assign o_ready   = w_adv;
    assign w_b_eff   = i_sub ? ~i_b : i_b;
    assign w_cin_eff = i_sub ? ~i_carry_in : i_carry_in;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operand bits not yet consumed when the beat enters this stage.
        localparam int c_in_w  = N - k * c_slice_w;
        localparam int c_res_w = (k + 1) * c_slice_w;

        logic [c_in_w-1:0]    w_a_in;
        logic [c_in_w-1:0]    w_b_in;
        logic                 w_cin;
        logic                 w_vld_in;
        logic [c_slice_w-1:0] w_sum;
        logic                 w_cout;

        logic                 r_vld;
        logic                 r_carry;
        logic [c_res_w-1:0]   r_res;

        adder #(.W(c_slice_w)) u_adder (
            .i_a    (w_a_in[c_slice_w-1:0]),
            .i_b    (w_b_in[c_slice_w-1:0]),
            .i_cin  (w_cin),
            .o_s    (w_sum),
            .o_cout (w_cout)
        );

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_vld   <= 1'b0;
                r_carry <= 1'b0;
            end else if (w_adv) begin
                r_vld   <= w_vld_in;
                r_carry <= w_cout;
            end
        end

        if (k == 0) begin : g_first
            assign w_a_in   = i_a;
            assign w_b_in   = w_b_eff;
            assign w_cin    = w_cin_eff;
            assign w_vld_in = i_valid;

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_res <= '0;
                end else if (w_adv) begin
                    r_res <= w_sum;
                end
            end
        end else begin : g_next
            assign w_a_in   = g_stage[k-1].g_opnd.r_a;
            assign w_b_in   = g_stage[k-1].g_opnd.r_b;
            assign w_cin    = g_stage[k-1].r_carry;
            assign w_vld_in = g_stage[k-1].r_vld;

            // Lower result slices ride along so all N bits leave together.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_res <= '0;
                end else if (w_adv) begin
                    r_res <= {w_sum, g_stage[k-1].r_res};
                end
            end
        end

        if (k < STAGES - 1) begin : g_opnd
            logic [c_in_w-c_slice_w-1:0] r_a;
            logic [c_in_w-c_slice_w-1:0] r_b;

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_adv) begin
                    r_a <= w_a_in[c_in_w-1:c_slice_w];
                    r_b <= w_b_in[c_in_w-1:c_slice_w];
                end
            end
        end

        if (k == STAGES - 1) begin : g_last
            logic r_ovf;

            // Carry into the MSB is recovered from the MSB sum bit.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_ovf <= 1'b0;
                end else if (w_adv) begin
                    r_ovf <= w_a_in[c_slice_w-1] ^ w_b_in[c_slice_w-1]
                           ^ w_sum[c_slice_w-1] ^ w_cout;
                end
            end
        end
    end

    assign o_valid     = g_stage[STAGES-1].r_vld;
    assign o_s         = g_stage[STAGES-1].r_res;
    assign o_carry_out = g_stage[STAGES-1].r_carry;
    assign o_overflow  = g_stage[STAGES-1].g_last.r_ovf;

endmodule
`default_nettype wire
